codec_init_sequencer: RTL and testbench

Upstream command source for `i2c_fsm`: after reset it waits a power-up delay, then walks a constant table of audio-codec register writes (7-bit register address, 9-bit data), handing each one to the I2C master as a two-byte write request over a valid/ready handshake. It waits for each transfer to complete and retries NACKed writes a bounded number of times. It reports overall completion or failure to the rest of the synth.

---
 rtl/synth_pkg.sv | 44 ++++
 rtl/delay_counter.sv | 31 +++
 rtl/codec_init_sequencer.sv | 118 +++++++++++
 tb/tb_codec_init_sequencer.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the synth control path: sequencer states, the codec
// register-write entry format and the codec power-on register table.
package synth_pkg;

    localparam logic [6:0] CODEC_I2C_ADDR = 7'h1A;
    localparam int         TABLE_LEN      = 10;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        POWERUP   = 4'd1,
        LOAD      = 4'd2,
        REQUEST   = 4'd3,
        WAIT_DONE = 4'd4,
        GAP       = 4'd5,
        DONE      = 4'd6,
        ERROR     = 4'd7
    } seq_state_t;

    typedef struct packed {
        logic [6:0] reg_addr;
        logic [8:0] data;
    } codec_reg_t;

    // R8 (sampling control) is left out: its power-on value 000 is already
    // the wanted setting, which keeps the table at ten writes.
    function automatic codec_reg_t table_entry(input logic [3:0] idx);
        codec_reg_t e;
        case (idx)
            4'd0:    e = {7'd15, 9'h000};
            4'd1:    e = {7'd0,  9'h017};
            4'd2:    e = {7'd1,  9'h017};
            4'd3:    e = {7'd2,  9'h079};
            4'd4:    e = {7'd3,  9'h079};
            4'd5:    e = {7'd4,  9'h012};
            4'd6:    e = {7'd5,  9'h000};
            4'd7:    e = {7'd6,  9'h000};
            4'd8:    e = {7'd7,  9'h002};
            4'd9:    e = {7'd9,  9'h001};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/delay_counter.sv
// Loadable down-counter; expired is high for one cycle when a loaded count
// of N has run through N+1 cycles (values N..0).
module delay_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         expired
);

    logic [W-1:0] count;
    logic         armed;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            armed <= 1'b0;
        end else if (load) begin
            count <= load_value;
            armed <= 1'b1;
        end else if (armed) begin
            if (count == '0) armed <= 1'b0;
            else             count <= count - W'(1);
        end
    end

    assign expired = armed && (count == '0);

endmodule

// File: rtl/codec_init_sequencer.sv
// Walks the codec register table after power-up, handing each write to the
// I2C master and retrying NACKed writes a bounded number of times.
module codec_init_sequencer
    import synth_pkg::*;
#(
    parameter int NUM_REGS       = 10,
    parameter int POWERUP_CYCLES = 1000,
    parameter int GAP_CYCLES     = 16,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       req_valid,
    input  logic       req_ready,
    output logic [7:0] req_byte0,
    output logic [7:0] req_byte1,
    input  logic       xfer_done,
    input  logic       xfer_nack,
    output logic       init_done,
    output logic       init_error,
    output logic [3:0] reg_index,
    output logic [3:0] state_info
);

    localparam int DLY_MAX = (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    seq_state_t         state, next_state;
    logic [RETRY_W-1:0] retry_cnt;
    logic               dly_load, dly_expired;
    logic [CNT_W-1:0]   dly_value;
    logic               last_entry;
    codec_reg_t         entry;

    assign last_entry = (reg_index == 4'(NUM_REGS - 1));
    assign entry      = table_entry(reg_index);
    assign state_info = state;

    delay_counter #(.W(CNT_W)) u_delay (
        .clk        (clk),
        .reset      (reset),
        .load       (dly_load),
        .load_value (dly_value),
        .expired    (dly_expired)
    );

    // Handshake: req_valid is high exactly while in REQUEST with the bytes held
    // stable; the write transfers on the cycle req_valid && req_ready, and
    // req_valid is low from the next cycle on.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      next_state = POWERUP;
            POWERUP:   if (dly_expired) next_state = LOAD;
            LOAD:      next_state = REQUEST;
            REQUEST:   if (req_valid && req_ready) next_state = WAIT_DONE;
            WAIT_DONE: begin
                if (xfer_done) begin
                    if (!xfer_nack)                               next_state = last_entry ? DONE : GAP;
                    else if (retry_cnt < RETRY_W'(MAX_RETRY))     next_state = GAP;
                    else                                          next_state = ERROR;
                end
            end
            GAP:       if (dly_expired) next_state = LOAD;
            DONE,
            ERROR:     if (start) next_state = POWERUP;
            default:   next_state = IDLE;
        endcase

        dly_load  = (next_state != state) && ((next_state == POWERUP) || (next_state == GAP));
        dly_value = (next_state == POWERUP) ? CNT_W'(POWERUP_CYCLES - 1) : CNT_W'(GAP_CYCLES - 1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            req_valid  <= 1'b0;
            req_byte0  <= '0;
            req_byte1  <= '0;
            init_done  <= 1'b0;
            init_error <= 1'b0;
            reg_index  <= '0;
            retry_cnt  <= '0;
        end else begin
            state      <= next_state;
            req_valid  <= (next_state == REQUEST);
            init_done  <= (next_state == DONE);
            init_error <= (next_state == ERROR);
            case (state)
                POWERUP: begin
                    if (dly_expired) begin
                        reg_index <= '0;
                        retry_cnt <= '0;
                    end
                end
                LOAD: begin
                    req_byte0 <= {entry.reg_addr, entry.data[8]};
                    req_byte1 <= entry.data[7:0];
                end
                WAIT_DONE: begin
                    // On the final NACK the count is left as is; ERROR follows.
                    if (xfer_done) begin
                        if (!xfer_nack) begin
                            retry_cnt <= '0;
                            if (!last_entry) reg_index <= reg_index + 4'd1;
                        end else if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + RETRY_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Bench for codec_init_sequencer: an I2C-master stand-in answers requests with
// random stalls, latencies and NACK plans; a table-level model predicts the writes.
module tb_codec_init_sequencer;

    localparam int NREG = 10;
    localparam int P    = 1000;
    localparam int G    = 16;
    localparam int MAXR = 3;

    localparam int TB_ADDR [NREG] = '{15, 0, 1, 2, 3, 4, 5, 6, 7, 9};
    localparam int TB_DATA [NREG] = '{'h000, 'h017, 'h017, 'h079, 'h079, 'h012, 'h000, 'h000, 'h002, 'h001};

    typedef int plan_t [NREG];

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       req_ready = 1'b0;
    logic       xfer_done = 1'b0;
    logic       xfer_nack = 1'b0;
    logic       req_valid, init_done, init_error;
    logic [7:0] req_byte0, req_byte1;
    logic [3:0] reg_index, state_info;

    int n_vec  = 0;
    int n_fail = 0;

    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];

    always #5 clk = ~clk;

    codec_init_sequencer #(
        .NUM_REGS(NREG), .POWERUP_CYCLES(P), .GAP_CYCLES(G), .MAX_RETRY(MAXR)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_byte0(req_byte0), .req_byte1(req_byte1),
        .xfer_done(xfer_done), .xfer_nack(xfer_nack),
        .init_done(init_done), .init_error(init_error),
        .reg_index(reg_index), .state_info(state_info)
    );

    // ---------------- reference model ----------------
    function automatic logic [15:0] expected_word(input int i);
        int b0, b1;
        b0 = TB_ADDR[i] * 2 + TB_DATA[i] / 256;
        b1 = TB_DATA[i] % 256;
        return {b0[7:0], b1[7:0]};
    endfunction

    // Fills exp_q with the writes the codec should see; returns 1 = done, 2 = error.
    function automatic int build_expected(input plan_t plan);
        int tries;
        exp_q.delete();
        for (int i = 0; i < NREG; i++) begin
            tries = (plan[i] > MAXR) ? MAXR + 1 : plan[i] + 1;
            for (int t = 0; t < tries; t++) exp_q.push_back(expected_word(i));
            if (plan[i] > MAXR) return 2;
        end
        return 1;
    endfunction

    function automatic int entry_of(input logic [7:0] b0);
        for (int i = 0; i < NREG; i++)
            if (TB_ADDR[i] == int'(b0 >> 1)) return i;
        return -1;
    endfunction

    // ---------------- drivers ----------------
    task automatic apply_reset();
        reset = 1'b0; start = 1'b0; req_ready = 1'b0; xfer_done = 1'b0; xfer_nack = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    // Serves requests until the DUT flags done/error. outcome: 1 done, 2 error,
    // 3 timeout, 4 runaway request count.
    task automatic serve(input plan_t plan, input bit hold_ready, input int max_stall,
                         input int min_lat, input int max_lat, input int start_at,
                         output int outcome);
        int nl[NREG];
        int cyc, lat, used, k, n_acc;
        nl = plan;
        obs_q.delete();
        outcome = 0;
        n_acc = 0;
        req_ready = hold_ready;
        while (outcome == 0) begin
            cyc = 0;
            while (!req_valid && !init_done && !init_error && cyc < 4000) begin
                @(negedge clk);
                cyc++;
            end
            if (init_done)             outcome = 1;
            else if (init_error)       outcome = 2;
            else if (!req_valid)       outcome = 3;
            else if (obs_q.size() > 60) outcome = 4;
            else begin
                if (!hold_ready) begin
                    repeat ($urandom_range(0, max_stall)) @(negedge clk);
                    req_ready = 1'b1;
                end
                obs_q.push_back({req_byte0, req_byte1});
                @(negedge clk);
                req_ready = hold_ready;
                n_acc++;
                used = 1;
                if (n_acc == start_at) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                    used++;
                end
                lat = $urandom_range(min_lat, max_lat);
                if (lat > used) repeat (lat - used) @(negedge clk);
                k = entry_of(obs_q[obs_q.size() - 1][15:8]);
                xfer_done = 1'b1;
                xfer_nack = (k >= 0) && (nl[k] > 0);
                if (k >= 0 && nl[k] > 0) nl[k]--;
                @(negedge clk);
                xfer_done = 1'b0;
                xfer_nack = 1'b0;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        req_ready = 1'($urandom_range(0, 1));
        repeat (4) @(negedge clk);
        n_vec++;
        if ({req_valid, init_done, init_error} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000", {req_valid, init_done, init_error});
        end
        n_vec++;
        if ({req_byte0, req_byte1} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_bytes: got %h want 0000", {req_byte0, req_byte1});
        end
        n_vec++;
        if (reg_index !== 4'd0) begin
            n_fail++; $display("FAIL reset_reg_index: got %0d want 0", reg_index);
        end
        n_vec++;
        if (state_info !== 4'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d want 0", state_info);
        end
    endtask

    task automatic test_powerup_timing();
        int cnt;
        apply_reset();
        cnt = 0;
        while (!req_valid && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        n_vec++;
        if (cnt != P + 2) begin
            n_fail++; $display("FAIL powerup_latency: got %0d want %0d", cnt, P + 2);
        end
        n_vec++;
        if ({req_byte0, req_byte1} !== 16'h1E00) begin
            n_fail++; $display("FAIL first_bytes: got %h want 1e00", {req_byte0, req_byte1});
        end
    endtask

    task automatic test_full_sequence();
        plan_t plan = '{default: 0};
        int outcome, want;
        want = build_expected(plan);
        serve(plan, 1'b1, 0, 20, 20, -1, outcome);
        n_vec++;
        if (outcome != want) begin
            n_fail++; $display("FAIL full_outcome: got %0d want %0d", outcome, want);
        end
        n_vec++;
        if ({init_done, init_error, state_info} !== {1'b1, 1'b0, 4'd6}) begin
            n_fail++; $display("FAIL full_flags: got done=%b err=%b st=%0d want 1 0 6", init_done, init_error, state_info);
        end
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL full_len: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL full_req[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_q.size() == NREG) begin
            n_vec++;
            if (obs_q[NREG - 1] !== 16'h1201) begin
                n_fail++; $display("FAIL last_bytes: got %h want 1201", obs_q[NREG - 1]);
            end
        end
    endtask

    // Restart from DONE; a second start during POWERUP and one mid-sequence are ignored.
    task automatic test_start();
        plan_t plan = '{default: 0};
        int cnt, outcome, want;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 1;
        n_vec++;
        if ({init_done, init_error, state_info} !== {1'b0, 1'b0, 4'd1}) begin
            n_fail++; $display("FAIL start_clear: got done=%b err=%b st=%0d want 0 0 1", init_done, init_error, state_info);
        end
        while (!req_valid && cnt < 3000) begin
            start = (cnt == 100);
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        n_vec++;
        if (cnt != P + 2) begin
            n_fail++; $display("FAIL restart_latency: got %0d want %0d", cnt, P + 2);
        end
        want = build_expected(plan);
        serve(plan, 1'b0, 3, 3, 12, 4, outcome);
        n_vec++;
        if (outcome != want) begin
            n_fail++; $display("FAIL restart_outcome: got %0d want %0d", outcome, want);
        end
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL restart_len: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL restart_req[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_gap_timing();
        int cyc;
        apply_reset();
        cyc = 0;
        while (!req_valid && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        n_vec++;
        if ({req_valid, state_info} !== {1'b0, 4'd4}) begin
            n_fail++; $display("FAIL accept_state: got v=%b st=%0d want 0 4", req_valid, state_info);
        end
        repeat (4) @(negedge clk);
        xfer_done = 1'b1;
        cyc = 0;
        while (cyc == 0 || (!req_valid && cyc < 200)) begin
            @(negedge clk);
            xfer_done = 1'b0;
            cyc++;
        end
        n_vec++;
        if (cyc != G + 2) begin
            n_fail++; $display("FAIL gap_latency: got %0d want %0d", cyc, G + 2);
        end
        n_vec++;
        if ({reg_index, req_byte0, req_byte1} !== {4'd1, expected_word(1)}) begin
            n_fail++; $display("FAIL second_req: got idx=%0d %h want 1 %h", reg_index, {req_byte0, req_byte1}, expected_word(1));
        end
    endtask

    // req_ready low for 50 cycles, with a stray xfer_done in the middle.
    task automatic test_ready_stall();
        int cyc;
        apply_reset();
        cyc = 0;
        while (!req_valid && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        for (int c = 0; c < 50; c++) begin
            xfer_done = (c == 10);
            xfer_nack = (c == 10);
            n_vec++;
            if ({req_valid, req_byte0, req_byte1, state_info} !== {1'b1, expected_word(0), 4'd3}) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got v=%b %h st=%0d want 1 %h 3",
                                   c, req_valid, {req_byte0, req_byte1}, state_info, expected_word(0));
            end
            @(negedge clk);
        end
        xfer_done = 1'b0;
        xfer_nack = 1'b0;
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        n_vec++;
        if ({req_valid, state_info} !== {1'b0, 4'd4}) begin
            n_fail++; $display("FAIL stall_accept: got v=%b st=%0d want 0 4", req_valid, state_info);
        end
    endtask

    task automatic test_nack_retry();
        plan_t plan = '{default: 0};
        int outcome, want, hits;
        plan[3] = 2;
        apply_reset();
        want = build_expected(plan);
        serve(plan, 1'b0, 4, 2, 10, -1, outcome);
        hits = 0;
        foreach (obs_q[i]) if (obs_q[i] === expected_word(3)) hits++;
        n_vec++;
        if (hits != 3) begin
            n_fail++; $display("FAIL retry_count: got %0d want 3", hits);
        end
        n_vec++;
        if (outcome != want || init_done !== 1'b1) begin
            n_fail++; $display("FAIL retry_outcome: got %0d done=%b want %0d 1", outcome, init_done, want);
        end
        n_vec++;
        if (obs_q != exp_q) begin
            n_fail++; $display("FAIL retry_seq: got %0d reqs want %0d", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_nack_error();
        plan_t plan = '{default: 0};
        int outcome, want, highs, cnt;
        plan[5] = 4;
        apply_reset();
        want = build_expected(plan);
        serve(plan, 1'b0, 2, 2, 8, -1, outcome);
        n_vec++;
        if (outcome != want) begin
            n_fail++; $display("FAIL error_outcome: got %0d want %0d", outcome, want);
        end
        n_vec++;
        if ({init_error, init_done, state_info} !== {1'b1, 1'b0, 4'd7}) begin
            n_fail++; $display("FAIL error_flags: got err=%b done=%b st=%0d want 1 0 7", init_error, init_done, state_info);
        end
        n_vec++;
        if (obs_q != exp_q) begin
            n_fail++; $display("FAIL error_seq: got %0d reqs want %0d", obs_q.size(), exp_q.size());
        end
        highs = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (req_valid) highs++;
        end
        n_vec++;
        if (highs != 0) begin
            n_fail++; $display("FAIL error_quiet: got %0d valid cycles want 0", highs);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if ({init_error, state_info} !== {1'b0, 4'd1}) begin
            n_fail++; $display("FAIL error_restart: got err=%b st=%0d want 0 1", init_error, state_info);
        end
        cnt = 0;
        plan[5] = 0;
        want = build_expected(plan);
        serve(plan, 1'b1, 0, 2, 6, -1, outcome);
        n_vec++;
        if (outcome != want || obs_q != exp_q) begin
            n_fail++; $display("FAIL error_recover: got %0d/%0d reqs want %0d/%0d", outcome, obs_q.size(), want, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        apply_reset();
        req_ready = 1'b1;
        for (int a = 0; a < 5; a++) begin
            cyc = 0;
            while (!req_valid && cyc < 4000) begin
                @(negedge clk);
                cyc++;
            end
            @(negedge clk);
            if (a < 4) begin
                repeat (3) @(negedge clk);
                xfer_done = 1'b1;
                @(negedge clk);
                xfer_done = 1'b0;
            end
        end
        n_vec++;
        if ({state_info, reg_index} !== {4'd4, 4'd4}) begin
            n_fail++; $display("FAIL mid_position: got st=%0d idx=%0d want 4 4", state_info, reg_index);
        end
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({req_valid, init_done, init_error, req_byte0, req_byte1, reg_index, state_info} !== 27'd0) begin
            n_fail++; $display("FAIL mid_reset: got v=%b d=%b e=%b %h idx=%0d st=%0d want all 0",
                               req_valid, init_done, init_error, {req_byte0, req_byte1}, reg_index, state_info);
        end
        reset = 1'b1;
        cyc = 0;
        while (!req_valid && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        req_ready = 1'b0;
        n_vec++;
        if (cyc != P + 2 || {reg_index, req_byte0, req_byte1} !== {4'd0, 16'h1E00}) begin
            n_fail++; $display("FAIL mid_restart: got %0d cyc idx=%0d %h want %0d 0 1e00", cyc, reg_index, {req_byte0, req_byte1}, P + 2);
        end
    endtask

    task automatic test_random();
        plan_t plan;
        int outcome, want, r;
        for (int run = 0; run < 3; run++) begin
            foreach (plan[i]) begin
                r = $urandom_range(0, 9);
                plan[i] = (r < 6) ? 0 : (r < 8) ? $urandom_range(1, MAXR) : MAXR + 1;
            end
            apply_reset();
            want = build_expected(plan);
            serve(plan, 1'($urandom_range(0, 1)), 5, 2, 9, -1, outcome);
            n_vec++;
            if (outcome != want) begin
                n_fail++; $display("FAIL rand%0d_outcome: got %0d want %0d", run, outcome, want);
            end
            n_vec++;
            if (obs_q.size() != exp_q.size()) begin
                n_fail++; $display("FAIL rand%0d_len: got %0d want %0d", run, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                n_vec++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rand%0d_req[%0d]: got %h want %h", run, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_powerup_timing();
        test_full_sequence();
        test_start();
        test_gap_timing();
        test_ready_stall();
        test_nack_retry();
        test_nack_error();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
